lfsr_load_arbiter: RTL and testbench

//  Shares one 20-bit LFSR load/mask generator between two key-holding requesters.

---
 rtl/lfsr_load_arbiter_pkg.sv | 24 ++
 rtl/lfsr_load_arbiter_lfsr20_step.sv | 28 ++
 rtl/lfsr_load_arbiter.sv | 127 ++++++++++++
 tb/tb_lfsr_load_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_load_arbiter_pkg.sv
// rtl/lfsr_load_arbiter_pkg.sv - shared state encoding and LFSR definition for the load arbiter
package lfsr_load_arbiter_pkg;

   localparam int LFSR_W = 20;

   // Feedback taps of the 20-bit shift-right LFSR
   localparam int TAP0 = 15;
   localparam int TAP1 = 11;
   localparam int TAP2 = 7;
   localparam int TAP3 = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEED    = 2'd1,
      ST_STREAM  = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   // One LFSR advance: shift right, feedback enters at the MSB
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3], s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_load_arbiter_lfsr20_step.sv
// rtl/lfsr_load_arbiter_lfsr20_step.sv - 20-bit LFSR register with seed load and advance enables
module lfsr20_step
   import lfsr_load_arbiter_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              adv_i,
   output logic [LFSR_W-1:0] lfsr_o
);

   logic [LFSR_W-1:0] lfsr_q;

   // Seed load wins over advance; otherwise the state holds
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= '0;
      end else if (load_i) begin
         lfsr_q <= seed_i;
      end else if (adv_i) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/lfsr_load_arbiter.sv
// rtl/lfsr_load_arbiter.sv - round-robin sharing of one LFSR load-word generator between two key holders
module lfsr_load_arbiter
   import lfsr_load_arbiter_pkg::*;
#(
   parameter int                BURST_LEN     = 4,
   parameter logic [63:0]       LOAD_XOR_MASK = 64'h8FADC1A6B5E37921,
   parameter logic [LFSR_W-1:0] LFSR_SEED     = 20'h99999
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req,
   input  logic [127:0] key0,
   input  logic [127:0] key1,
   output logic [1:0]   gnt,
   output logic         load_valid,
   input  logic         load_ready,
   output logic [63:0]  load_data,
   output logic         load_last,
   output logic         load_owner,
   output logic         busy
);

   localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   state_e             state_q;
   logic [127:0]       key_q;
   logic [BEAT_W-1:0]  beat_q;
   logic [1:0]         gnt_q;
   logic               valid_q;
   logic               owner_q;
   logic               busy_q;
   logic               last_srv_q;   // requester served most recently

   logic               win_d;
   logic [LFSR_W-1:0]  seed_x;
   logic [LFSR_W-1:0]  seed_d;
   logic [LFSR_W-1:0]  lfsr;
   logic               is_last;
   logic [63:0]        key_half;
   logic [63:0]        lfsr_rep;

   // Round-robin pick: on contention the requester not served last wins
   always_comb begin
      win_d = 1'b0;
      if (req == 2'b11) begin
         win_d = ~last_srv_q;
      end else begin
         win_d = req[1];
      end
   end

   // A zero seed would lock the LFSR, so fall back to the base seed
   assign seed_x = key_q[LFSR_W-1:0] ^ LFSR_SEED;
   assign seed_d = (seed_x == '0) ? LFSR_SEED : seed_x;

   lfsr20_step u_lfsr (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (state_q == ST_SEED),
      .seed_i (seed_d),
      .adv_i  (valid_q & load_ready),
      .lfsr_o (lfsr)
   );

   // Word i uses lfsr bit i%20, hence the 20-bit pattern tiled over 64 bits
   assign is_last  = (beat_q == LAST_BEAT);
   assign key_half = beat_q[0] ? key_q[127:64] : key_q[63:0];
   assign lfsr_rep = {lfsr[3:0], lfsr, lfsr, lfsr};

   assign load_data  = (state_q == ST_STREAM) ? (key_half ^ lfsr_rep ^ LOAD_XOR_MASK) : 64'd0;
   assign load_last  = (state_q == ST_STREAM) & is_last;
   assign gnt        = gnt_q;
   assign load_valid = valid_q;
   assign load_owner = owner_q;
   assign busy       = busy_q;

   // Burst control FSM with registered grant/valid/busy/owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         beat_q     <= '0;
         gnt_q      <= 2'b00;
         valid_q    <= 1'b0;
         owner_q    <= 1'b0;
         busy_q     <= 1'b0;
         last_srv_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  owner_q <= win_d;
                  key_q   <= win_d ? key1 : key0;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  busy_q  <= 1'b1;
                  state_q <= ST_SEED;
               end
            end
            ST_SEED: begin
               beat_q  <= '0;
               valid_q <= 1'b1;
               state_q <= ST_STREAM;
            end
            ST_STREAM: begin
               if (load_ready) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (is_last) begin
                     gnt_q   <= 2'b00;
                     valid_q <= 1'b0;
                     state_q <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               last_srv_q <= owner_q;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_load_arbiter.sv
// tb/tb_lfsr_load_arbiter.sv - directed self-checking bench for lfsr_load_arbiter
module tb_lfsr_load_arbiter;

   localparam int          BL   = 4;
   localparam logic [63:0] MASK = 64'h8FADC1A6B5E37921;
   localparam logic [19:0] SEED = 20'h99999;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req;
   logic [127:0] key0;
   logic [127:0] key1;
   logic [1:0]   gnt;
   logic         load_valid;
   logic         load_ready;
   logic [63:0]  load_data;
   logic         load_last;
   logic         load_owner;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   lfsr_load_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .key0       (key0),
      .key1       (key1),
      .gnt        (gnt),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_owner (load_owner),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] m_seed(input logic [19:0] k);
      logic [19:0] s;
      s = k ^ SEED;
      if (s == 20'd0) s = SEED;
      return s;
   endfunction

   function automatic logic [19:0] m_step(input logic [19:0] l);
      logic [19:0] n;
      n     = l >> 1;
      n[19] = l[15] ^ l[11] ^ l[7] ^ l[0];
      return n;
   endfunction

   function automatic logic [63:0] m_word(input logic [127:0] k, input logic [19:0] l, input int b);
      logic [63:0] w;
      for (int i = 0; i < 64; i++) w[i] = k[i + 64 * (b % 2)] ^ l[i % 20] ^ MASK[i];
      return w;
   endfunction

   // Wait for a burst, then check every word against the model; ends on the RELEASE cycle
   task automatic do_burst(input logic exp_owner, input logic [127:0] key, input bit stall,
                           input bit withdraw, output int waited);
      logic [19:0] l;
      logic [1:0]  eg;
      int          beat;
      int          step;
      bit          r;
      l      = m_seed(key[19:0]);
      eg     = exp_owner ? 2'b10 : 2'b01;
      waited = 0;
      while (!load_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("valid_wait", 64'(load_valid), 64'd1);
      chk("owner", 64'(load_owner), 64'(exp_owner));
      chk("busy", 64'(busy), 64'd1);
      beat = 0;
      step = 0;
      while (beat < BL && step < 40) begin
         chk("valid", 64'(load_valid), 64'd1);
         chk("gnt", 64'(gnt), 64'(eg));
         chk("data", load_data, m_word(key, l, beat));
         chk("last", 64'(load_last), 64'(beat == BL - 1));
         r = stall ? (step != 1 && step != 2) : 1'b1;
         load_ready = r;
         if (withdraw && beat == 1 && r) begin
            req  = 2'b00;
            key0 = ~key0;
         end
         @(negedge clk);
         step++;
         if (r) begin
            l = m_step(l);
            beat++;
         end
      end
      load_ready = 1'b1;
      chk("beats", 64'(beat), 64'(BL));
      chk("rel_gnt", 64'(gnt), 64'd0);
      chk("rel_valid", 64'(load_valid), 64'd0);
      chk("rel_data", load_data, 64'd0);
      chk("rel_last", 64'(load_last), 64'd0);
   endtask

   initial begin
      int w;
      logic [127:0] ka;
      logic [127:0] kb;
      rst        = 1'b1;
      req        = 2'b00;
      key0       = '0;
      key1       = '0;
      load_ready = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_valid", 64'(load_valid), 64'd0);
      chk("rst_data", load_data, 64'd0);
      chk("rst_last", 64'(load_last), 64'd0);
      chk("rst_owner", 64'(load_owner), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1. basic burst, latency and known first word
      req = 2'b01;
      @(negedge clk);
      chk("t1_gnt_n1", 64'(gnt), 64'd1);
      chk("t1_valid_n1", 64'(load_valid), 64'd0);
      req = 2'b00;
      @(negedge clk);
      chk("t1_valid_n2", 64'(load_valid), 64'd1);
      chk("t1_word0", load_data, 64'h1634583F2C7AE0B8);
      do_burst(1'b0, 128'd0, 1'b0, 1'b0, w);
      repeat (3) @(negedge clk);
      chk("t1_idle_busy", 64'(busy), 64'd0);

      // 2. zero-seed fallback
      key0 = 128'h99999;
      req  = 2'b01;
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      chk("t2_word0", load_data, 64'h1634583F2C737921);
      do_burst(1'b0, 128'h99999, 1'b0, 1'b0, w);
      repeat (3) @(negedge clk);

      // 4. backpressure
      ka   = 128'h0123456789ABCDEF_FEDCBA9876543210;
      key0 = ka;
      req  = 2'b01;
      @(negedge clk);
      req = 2'b00;
      do_burst(1'b0, ka, 1'b1, 1'b0, w);
      repeat (3) @(negedge clk);

      // 5. withdrawal and key change mid-burst
      ka   = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
      key0 = ka;
      req  = 2'b01;
      @(negedge clk);
      do_burst(1'b0, ka, 1'b0, 1'b1, w);
      req = 2'b00;
      repeat (3) @(negedge clk);
      chk("t5_no_regrant", 64'(busy), 64'd0);

      // 3. contention from a fresh reset: owners alternate 0,1,0,1
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      ka   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
      kb   = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      key0 = ka;
      key1 = kb;
      req  = 2'b11;
      do_burst(1'b0, ka, 1'b0, 1'b0, w);
      do_burst(1'b1, kb, 1'b0, 1'b0, w);
      chk("t3_dead_cycles", 64'(w), 64'd3);
      do_burst(1'b0, ka, 1'b0, 1'b0, w);
      do_burst(1'b1, kb, 1'b0, 1'b0, w);
      req = 2'b00;
      repeat (3) @(negedge clk);

      // 6. async reset mid-burst, then requester 1 alone
      ka   = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      key0 = ka;
      req  = 2'b01;
      w    = 0;
      while (!load_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("t6_valid", 64'(load_valid), 64'd1);
      repeat (2) @(negedge clk);
      chk("t6_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_gnt", 64'(gnt), 64'd0);
      chk("t6_valid_lo", 64'(load_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_data", load_data, 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      kb   = 128'h76543210_FEDCBA98_01234567_89ABCDEF;
      key1 = kb;
      req  = 2'b10;
      do_burst(1'b1, kb, 1'b0, 1'b0, w);
      req = 2'b00;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
